// File: rtl/ch_bist_if.sv
// ============================================================================
// Module   : ch_bist_if
// Purpose  : Counter/SRAM/status bundle between the BIST engine and its world.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface ch_bist_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 4,
  parameter int ERR_W  = ADDR_W + 2
);
  logic                start;
  logic [ADDR_W+1:0]   cnt_in;
  logic                cnt_cout;
  logic                cnt_cen;
  logic                cnt_rst;
  logic                sram_cs;
  logic                sram_we;
  logic [ADDR_W-1:0]   sram_addr;
  logic [DATA_W-1:0]   sram_wdata;
  logic [DATA_W-1:0]   sram_rdata;
  logic                busy;
  logic                done;
  logic                pass;
  logic [ERR_W-1:0]    err_cnt;
  logic                fail_valid;
  logic [ADDR_W-1:0]   fail_addr;

  // Engine side
  modport slave (
    input  start, cnt_in, cnt_cout, sram_rdata,
    output cnt_cen, cnt_rst, sram_cs, sram_we, sram_addr, sram_wdata,
           busy, done, pass, err_cnt, fail_valid, fail_addr
  );

  // Environment side: counter, SRAM and controller
  modport master (
    output start, cnt_in, cnt_cout, sram_rdata,
    input  cnt_cen, cnt_rst, sram_cs, sram_we, sram_addr, sram_wdata,
           busy, done, pass, err_cnt, fail_valid, fail_addr
  );
endinterface

`default_nettype wire

// File: rtl/ch_bist_engine.sv
// ============================================================================
// Module   : ch_bist_engine
// Purpose  : Checkerboard BIST sequencer/comparator for a small SRAM.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ch_bist_engine #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 4,
  parameter int RD_LAT = 1,
  parameter int ERR_W  = ADDR_W + 2
) (
  input  logic     clk,
  input  logic     rst,
  ch_bist_if.slave bus
);

  localparam logic [ADDR_W+1:0] c_LAST = {1'b1, 1'b0, {ADDR_W{1'b1}}};
  localparam logic [DATA_W-1:0] c_PAT0 = {(DATA_W/2){2'b01}};
  localparam logic [DATA_W-1:0] c_PAT1 = {(DATA_W/2){2'b10}};
  localparam logic [2:0]        c_DRAIN_END = 3'(RD_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [2:0]          r_drain_cnt;
  logic                r_pv    [RD_LAT];
  logic [DATA_W-1:0]   r_pexp  [RD_LAT];
  logic [ADDR_W-1:0]   r_paddr [RD_LAT];
  logic [ERR_W-1:0]    r_err_cnt;
  logic                r_fail_valid;
  logic [ADDR_W-1:0]   r_fail_addr;

  logic [DATA_W-1:0]   w_pat;
  logic                w_seq_err;
  logic                w_push;
  logic                w_mis;
  logic                w_clear;
  logic [ERR_W:0]      w_sum;
  logic [ERR_W-1:0]    w_err_nxt;

  assign w_pat     = bus.cnt_in[ADDR_W+1] ? c_PAT1 : c_PAT0;
  // Inverted-pass flag ahead of the pattern bit means the counter skipped ahead
  assign w_seq_err = (r_state == S_RUN) && bus.cnt_cout && !bus.cnt_in[ADDR_W+1];
  assign w_push    = (r_state == S_RUN) && !bus.cnt_in[ADDR_W] && !w_seq_err;
  assign w_mis     = r_pv[RD_LAT-1] && (bus.sram_rdata != r_pexp[RD_LAT-1]);
  assign w_clear   = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_sum     = {1'b0, r_err_cnt} + {{ERR_W{1'b0}}, w_mis} + {{ERR_W{1'b0}}, w_seq_err};
  assign w_err_nxt = w_sum[ERR_W] ? {ERR_W{1'b1}} : w_sum[ERR_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst || (r_state != S_DRAIN)) r_drain_cnt <= 3'd0;
    else                             r_drain_cnt <= r_drain_cnt + 3'd1;
  end

  always_comb begin
    w_state_nxt    = r_state;
    bus.cnt_cen    = 1'b0;
    bus.cnt_rst    = 1'b0;
    bus.sram_cs    = 1'b0;
    bus.sram_we    = 1'b0;
    bus.sram_addr  = '0;
    bus.sram_wdata = '0;
    bus.busy       = 1'b0;
    bus.done       = 1'b0;
    case (r_state)
      S_IDLE: if (bus.start) w_state_nxt = S_CLR;
      S_CLR: begin
        bus.busy    = 1'b1;
        bus.cnt_rst = 1'b1;
        w_state_nxt = S_RUN;
      end
      S_RUN: begin
        bus.busy       = 1'b1;
        bus.cnt_cen    = 1'b1;
        bus.sram_cs    = 1'b1;
        bus.sram_we    = bus.cnt_in[ADDR_W];
        bus.sram_addr  = bus.cnt_in[ADDR_W-1:0];
        bus.sram_wdata = w_pat;
        if (bus.cnt_in == c_LAST) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        bus.busy = 1'b1;
        if (r_drain_cnt == c_DRAIN_END) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        bus.done = 1'b1;
        if (bus.start) w_state_nxt = S_CLR;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Expected-data pipeline aligned with the SRAM read latency
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) begin
        r_pv[i]    <= 1'b0;
        r_pexp[i]  <= '0;
        r_paddr[i] <= '0;
      end
    end else begin
      r_pv[0]    <= w_push;
      r_pexp[0]  <= w_pat;
      r_paddr[0] <= bus.cnt_in[ADDR_W-1:0];
      for (int i = 1; i < RD_LAT; i++) begin
        r_pv[i]    <= r_pv[i-1];
        r_pexp[i]  <= r_pexp[i-1];
        r_paddr[i] <= r_paddr[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || w_clear) begin
      r_err_cnt    <= '0;
      r_fail_valid <= 1'b0;
      r_fail_addr  <= '0;
    end else begin
      r_err_cnt <= w_err_nxt;
      if (w_mis && !r_fail_valid) begin
        r_fail_valid <= 1'b1;
        r_fail_addr  <= r_paddr[RD_LAT-1];
      end
    end
  end

  assign bus.err_cnt    = r_err_cnt;
  assign bus.fail_valid = r_fail_valid;
  assign bus.fail_addr  = r_fail_addr;
  assign bus.pass       = (r_state == S_DONE) && (r_err_cnt == '0);

endmodule

`default_nettype wire

// File: tb/tb_ch_bist_engine.sv
// ============================================================================
// Module   : tb_ch_bist_engine
// Purpose  : Randomized self-checking bench with counter/SRAM/fault models.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ch_bist_engine;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Per-instance controls; instance g uses RD_LAT = g+1
  logic [1:0]       start_i    = '0;
  logic [1:0]       cout_force = '0;
  logic [1:0]       fault_en   = '0;
  logic [1:0]       fault_val  = '0;
  logic [1:0]       zero_all   = '0;
  logic [1:0][7:0]  fault_addr = '0;
  logic [1:0][3:0]  fault_mask = '0;

  logic [1:0]       done_o, busy_o, pass_o, fv_o, cs_o, we_o, cen_o, crst_o;
  logic [1:0][9:0]  err_o;
  logic [1:0][7:0]  fa_o, addr_o;
  logic [1:0][3:0]  wdata_o;

  int n_checks = 0;
  int n_errors = 0;

  function automatic logic [3:0] apply_fault(input int g, input logic [3:0] d, input logic [7:0] a);
    if (zero_all[g]) return 4'h0;
    if (fault_en[g] && a == fault_addr[g])
      return fault_val[g] ? (d | fault_mask[g]) : (d & ~fault_mask[g]);
    return d;
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam int LAT = gi + 1;
    ch_bist_if #(.ADDR_W(8), .DATA_W(4), .ERR_W(10)) bus ();

    ch_bist_engine #(.ADDR_W(8), .DATA_W(4), .RD_LAT(LAT), .ERR_W(10)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
    );

    // Upstream checkerboard counter: raw count decoded to {p, write, addr}
    logic [9:0] raw;
    always @(posedge clk) begin
      if (rst || bus.cnt_rst) raw <= '0;
      else if (bus.cnt_cen)   raw <= raw + 10'd1;
    end
    assign bus.cnt_in   = {raw[9], ~raw[8], raw[7:0]};
    assign bus.cnt_cout = raw[9] | cout_force[gi];
    assign bus.start    = start_i[gi];

    logic [3:0] mem   [256];
    logic [3:0] rpipe [LAT];
    initial for (int i = 0; i < 256; i++) mem[i] = 4'h0;
    always @(posedge clk) begin
      if (bus.sram_cs && bus.sram_we) mem[bus.sram_addr] <= bus.sram_wdata;
      rpipe[0] <= apply_fault(gi, mem[bus.sram_addr], bus.sram_addr);
      for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
    end
    assign bus.sram_rdata = rpipe[LAT-1];

    assign done_o[gi]  = bus.done;
    assign busy_o[gi]  = bus.busy;
    assign pass_o[gi]  = bus.pass;
    assign fv_o[gi]    = bus.fail_valid;
    assign fa_o[gi]    = bus.fail_addr;
    assign err_o[gi]   = bus.err_cnt;
    assign cs_o[gi]    = bus.sram_cs;
    assign we_o[gi]    = bus.sram_we;
    assign cen_o[gi]   = bus.cnt_cen;
    assign crst_o[gi]  = bus.cnt_rst;
    assign addr_o[gi]  = bus.sram_addr;
    assign wdata_o[gi] = bus.sram_wdata;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Test outcome from the algorithm itself: two passes, each writes every
  // address then reads every address; cycles flagged as sequencing errors
  // count once and are never compared.
  task automatic ref_model(input int g, input int s, input int k,
                           output int exp_err, output logic exp_fv, output logic [7:0] exp_fa);
    exp_err = 0; exp_fv = 1'b0; exp_fa = 8'h00;
    for (int j = 0; j < 1024; j++) begin
      int p;
      bit wr;
      logic [7:0] a;
      logic [3:0] pat;
      p   = j / 512;
      wr  = (j % 512) < 256;
      a   = 8'(j % 256);
      pat = (p == 1) ? 4'hA : 4'h5;
      if (j >= s && j < s + k) begin
        exp_err++;
      end else if (!wr && apply_fault(g, pat, a) != pat) begin
        exp_err++;
        if (!exp_fv) begin
          exp_fv = 1'b1;
          exp_fa = a;
        end
      end
    end
  endtask

  task automatic clear_faults();
    fault_en = '0; fault_val = '0; zero_all = '0; fault_addr = '0; fault_mask = '0;
  endtask

  task automatic run_test(input int g, input string tag, input int s, input int k, input int restart_at);
    int n;
    int exp_err;
    logic exp_fv;
    logic [7:0] exp_fa;
    bit fin;
    ref_model(g, s, k, exp_err, exp_fv, exp_fa);
    start_i[g] = 1'b1;
    @(posedge clk); #1;
    start_i[g] = 1'b0;
    n = 1;
    check({tag, ".clr_err"}, 32'(err_o[g]), 32'd0);
    check({tag, ".busy"}, 32'(busy_o[g]), 32'd1);
    fin = 1'b0;
    while (n < 1200 && !fin) begin
      cout_force[g] = ((n - 2) >= s) && ((n - 2) < s + k);
      start_i[g]    = (restart_at >= 0) && ((n - 2) == restart_at);
      @(posedge clk); #1;
      n++;
      if (done_o[g]) fin = 1'b1;
    end
    cout_force[g] = 1'b0;
    start_i[g]    = 1'b0;
    check({tag, ".finished"}, 32'(fin), 32'd1);
    check({tag, ".latency"}, 32'(n), 32'(1027 + g));
    check({tag, ".err_cnt"}, 32'(err_o[g]), 32'(exp_err));
    check({tag, ".pass"}, 32'(pass_o[g]), 32'(exp_err == 0));
    check({tag, ".fail_valid"}, 32'(fv_o[g]), 32'(exp_fv));
    if (exp_fv) check({tag, ".fail_addr"}, 32'(fa_o[g]), 32'(exp_fa));
    repeat (3) @(posedge clk);
    #1;
    check({tag, ".done_hold"}, 32'(done_o[g]), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".done"}, 32'(done_o[0]), 32'd0);
    check({tag, ".busy"}, 32'(busy_o[0]), 32'd0);
    check({tag, ".pass"}, 32'(pass_o[0]), 32'd0);
    check({tag, ".err"}, 32'(err_o[0]), 32'd0);
    check({tag, ".fv"}, 32'(fv_o[0]), 32'd0);
    check({tag, ".fa"}, 32'(fa_o[0]), 32'd0);
    check({tag, ".cs"}, 32'(cs_o[0]), 32'd0);
    check({tag, ".we"}, 32'(we_o[0]), 32'd0);
    check({tag, ".cen"}, 32'(cen_o[0]), 32'd0);
    check({tag, ".crst"}, 32'(crst_o[0]), 32'd0);
    check({tag, ".addr"}, 32'(addr_o[0]), 32'd0);
    check({tag, ".wdata"}, 32'(wdata_o[0]), 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Fault-free run
    clear_faults();
    run_test(0, "t1", 0, 0, -1);

    // Stuck-at-1 on bit0 of address 0x05
    clear_faults();
    fault_en[0] = 1'b1; fault_addr[0] = 8'h05; fault_mask[0] = 4'h1; fault_val[0] = 1'b1;
    run_test(0, "t2", 0, 0, -1);

    // Every read returns zero
    clear_faults();
    zero_all[0] = 1'b1;
    run_test(0, "t3", 0, 0, -1);

    // Abort mid-RUN
    clear_faults();
    start_i[0] = 1'b1;
    @(posedge clk); #1;
    start_i[0] = 1'b0;
    repeat (301) @(posedge clk);
    #1;
    check("t4.running_cs", 32'(cs_o[0]), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("t4.abort");
    rst = 1'b0;
    @(posedge clk); #1;
    check("t4.no_access", 32'(cs_o[0]), 32'd0);
    run_test(0, "t4.rerun", 0, 0, -1);

    // Start ignored while busy, then restart from DONE with a fault present
    run_test(0, "t5", 0, 0, 10);
    fault_en[0] = 1'b1; fault_addr[0] = 8'hC3; fault_mask[0] = 4'h4; fault_val[0] = 1'b1;
    run_test(0, "t5.redo", 0, 0, -1);

    // Two-cycle read latency, bit3 stuck-at-0 at 0xFF
    clear_faults();
    fault_en[1] = 1'b1; fault_addr[1] = 8'hFF; fault_mask[1] = 4'h8; fault_val[1] = 1'b0;
    run_test(1, "t6", 0, 0, -1);

    // Sequencing errors during the first pass
    clear_faults();
    run_test(0, "seq", 300, 3, -1);

    // Randomized fault placement on either latency
    for (int r = 0; r < 5; r++) begin
      int g;
      int s;
      int k;
      g = int'($urandom_range(0, 1));
      clear_faults();
      fault_en[g]   = 1'b1;
      fault_addr[g] = 8'($urandom_range(0, 255));
      fault_mask[g] = 4'(1 << $urandom_range(0, 3));
      fault_val[g]  = 1'($urandom_range(0, 1));
      s = int'($urandom_range(0, 500));
      k = (r % 2 == 1) ? int'($urandom_range(1, 4)) : 0;
      run_test(g, $sformatf("rnd%0d", r), s, k, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
